ray_sample_collector: RTL and testbench

Output stage of the NeRF MLP accelerator. Sits directly downstream of the MLP core and consumes its per-sample RGB+sigma result vectors through a valid/ready handshake. It buffers whole samples in a small FIFO and serialises them into single-word memory writes with generated byte addresses. It flags the last word of every ray and signals completion after SAMPLE_CNT samples have been written.

---
 rtl/mlp_pkg.sv | 19 +
 rtl/ray_sample_collector_sample_fifo.sv | 52 +++++
 rtl/ray_sample_collector.sv | 161 ++++++++++++++++
 tb/tb_ray_sample_collector.sv | 338 +++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/mlp_pkg.sv
// Shared definitions for the NeRF MLP accelerator output stage:
// default word geometry, the collector state type and a NaN test helper.
package mlp_pkg;

   localparam int DEF_DATA_W  = 32;
   localparam int DEF_OUT_DIM = 4;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      RUN  = 2'd1,
      DONE = 2'd2
   } collector_state_t;

   // Single-precision NaN: exponent all ones with a non-zero mantissa.
   function automatic logic is_nan(input logic [31:0] word);
      return (word[30:23] == 8'hFF) && (word[22:0] != 23'd0);
   endfunction

endpackage

// File: rtl/ray_sample_collector_sample_fifo.sv
// Sample-wide FIFO for ray_sample_collector. One entry holds a whole
// sample; pointers carry an extra wrap bit so full and empty are distinct.
module sample_fifo #(
   parameter int WIDTH = 128,
   parameter int DEPTH = 8
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             clear,
   input  logic             push,
   input  logic [WIDTH-1:0] push_data,
   input  logic             pop,
   output logic             full,
   output logic             empty,
   output logic [WIDTH-1:0] head
);

   localparam int IDX_W = $clog2(DEPTH);

   logic [IDX_W:0]   wr_ptr;
   logic [IDX_W:0]   rd_ptr;
   logic [WIDTH-1:0] mem [DEPTH];
   logic             do_push;
   logic             do_pop;

   assign empty   = (wr_ptr == rd_ptr);
   assign full    = (wr_ptr[IDX_W] != rd_ptr[IDX_W]) &&
                    (wr_ptr[IDX_W-1:0] == rd_ptr[IDX_W-1:0]);
   assign do_push = push && !full;
   assign do_pop  = pop && !empty;
   assign head    = mem[rd_ptr[IDX_W-1:0]];

   // Pointer update; clear drops every stored entry at the start of a job.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
      end else if (clear) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
      end else begin
         if (do_push) wr_ptr <= wr_ptr + 1'b1;
         if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
      end
   end

   // Storage array; contents need no reset because the pointers gate them.
   always_ff @(posedge clk) begin
      if (do_push) mem[wr_ptr[IDX_W-1:0]] <= push_data;
   end

endmodule

// File: rtl/ray_sample_collector.sv
// Output stage of the NeRF MLP accelerator: buffers whole RGB+sigma samples
// and serialises them into single-word memory writes with byte addresses,
// marking the last word of each ray and pulsing done after SAMPLE_CNT samples.
// Optional feature: define RAY_COLLECT_NAN_CNT_EN to add the nan_cnt port.
module ray_sample_collector
   import mlp_pkg::*;
#(
   parameter int DATA_W          = DEF_DATA_W,
   parameter int OUT_DIM         = DEF_OUT_DIM,
   parameter int SAMPLE_CNT      = 65536,
   parameter int SAMPLES_PER_RAY = 64,
   parameter int FIFO_DEPTH      = 8,
   parameter int ADDR_W          = 32
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              start,
   input  logic [ADDR_W-1:0] base_addr,
   output logic              busy,
   output logic              done,
   input  logic [DATA_W-1:0] in_data [OUT_DIM],
   input  logic              in_valid,
   output logic              in_ready,
   output logic [ADDR_W-1:0] wr_addr,
   output logic [DATA_W-1:0] wr_data,
   output logic              wr_valid,
   input  logic              wr_ready,
   output logic              wr_ray_end
`ifdef RAY_COLLECT_NAN_CNT_EN
   ,
   output logic [31:0]       nan_cnt
`endif
);

   localparam int CNT_W  = $clog2(SAMPLE_CNT + 1);
   localparam int BEAT_W = (OUT_DIM > 1) ? $clog2(OUT_DIM) : 1;
   localparam int FIFO_W = DATA_W * OUT_DIM;

   localparam logic [CNT_W-1:0]  SAMPLE_CNT_C = CNT_W'(SAMPLE_CNT);
   localparam logic [CNT_W-1:0]  RAY_C        = CNT_W'(SAMPLES_PER_RAY);
   localparam logic [BEAT_W-1:0] BEAT_LAST    = BEAT_W'(OUT_DIM - 1);

   collector_state_t  state;
   logic [ADDR_W-1:0] base;
   logic [CNT_W-1:0]  acc_cnt;
   logic [CNT_W-1:0]  wr_cnt;
   logic [BEAT_W-1:0] beat;

   logic              fifo_full;
   logic              fifo_empty;
   logic [FIFO_W-1:0] push_word;
   logic [FIFO_W-1:0] head;
   logic [DATA_W-1:0] head_word;
   logic [ADDR_W-1:0] word_idx;

   logic job_start;
   logic push;
   logic beat_fire;
   logic last_beat;
   logic pop;

   assign job_start = (state == IDLE) && start;
   assign in_ready  = (state == RUN) && !fifo_full && (acc_cnt < SAMPLE_CNT_C);
   assign push      = in_valid && in_ready;
   assign wr_valid  = (state == RUN) && !fifo_empty;
   assign beat_fire = wr_valid && wr_ready;
   assign last_beat = (beat == BEAT_LAST);
   assign pop       = beat_fire && last_beat;

   assign head_word  = head[int'(beat)*DATA_W +: DATA_W];
   assign wr_data    = wr_valid ? head_word : '0;
   assign word_idx   = ADDR_W'(wr_cnt) * ADDR_W'(OUT_DIM) + ADDR_W'(beat);
   assign wr_addr    = base + (word_idx << 2);
   assign wr_ray_end = wr_valid && last_beat && ((wr_cnt % RAY_C) == (RAY_C - CNT_W'(1)));

   // Pack the incoming sample words into one FIFO entry, word 0 in the low bits.
   always_comb begin
      push_word = '0;
      for (int i = 0; i < OUT_DIM; i++) begin
         push_word[i*DATA_W +: DATA_W] = in_data[i];
      end
   end

   sample_fifo #(
      .WIDTH (FIFO_W),
      .DEPTH (FIFO_DEPTH)
   ) u_fifo (
      .clk       (clk),
      .rst_n     (rst_n),
      .clear     (job_start),
      .push      (push),
      .push_data (push_word),
      .pop       (pop),
      .full      (fifo_full),
      .empty     (fifo_empty),
      .head      (head)
   );

   // Job FSM with the sample counters and the beat serialiser.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state   <= IDLE;
         base    <= '0;
         acc_cnt <= '0;
         wr_cnt  <= '0;
         beat    <= '0;
         busy    <= 1'b0;
         done    <= 1'b0;
      end else begin
         done <= 1'b0;
         case (state)
            IDLE: begin
               if (start) begin
                  base    <= base_addr;
                  acc_cnt <= '0;
                  wr_cnt  <= '0;
                  beat    <= '0;
                  busy    <= 1'b1;
                  state   <= RUN;
               end
            end
            RUN: begin
               if (push) acc_cnt <= acc_cnt + CNT_W'(1);
               if (beat_fire) begin
                  if (last_beat) begin
                     beat   <= '0;
                     wr_cnt <= wr_cnt + CNT_W'(1);
                     if (wr_cnt == SAMPLE_CNT_C - CNT_W'(1)) begin
                        busy  <= 1'b0;
                        done  <= 1'b1;
                        state <= DONE;
                     end
                  end else begin
                     beat <= beat + BEAT_W'(1);
                  end
               end
            end
            DONE: begin
               state <= IDLE;
            end
            default: begin
               state <= IDLE;
            end
         endcase
      end
   end

`ifdef RAY_COLLECT_NAN_CNT_EN
   // Saturating count of NaN words accepted by memory during the current job.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         nan_cnt <= '0;
      end else if (job_start) begin
         nan_cnt <= '0;
      end else if (beat_fire && is_nan(wr_data[31:0]) && (nan_cnt != 32'hFFFF_FFFF)) begin
         nan_cnt <= nan_cnt + 32'd1;
      end
   end
`endif

endmodule

// File: tb/tb_ray_sample_collector.sv
// Self-checking bench for ray_sample_collector (SAMPLE_CNT=8,
// SAMPLES_PER_RAY=4, FIFO_DEPTH=4). A queue-based model of expected write
// beats is built from accepted samples and compared every cycle.
// Define RAY_COLLECT_NAN_CNT_EN to also exercise the nan_cnt port.
module tb_ray_sample_collector;

   localparam int SC  = 8;
   localparam int SPR = 4;
   localparam int FD  = 4;
   localparam int OD  = 4;

   logic        clk;
   logic        rst_n;
   logic        start;
   logic [31:0] base_addr;
   logic        busy;
   logic        done;
   logic [31:0] in_data [OD];
   logic        in_valid;
   logic        in_ready;
   logic [31:0] wr_addr;
   logic [31:0] wr_data;
   logic        wr_valid;
   logic        wr_ready;
   logic        wr_ray_end;
`ifdef RAY_COLLECT_NAN_CNT_EN
   logic [31:0] nan_cnt;
`endif

   typedef struct {
      logic [31:0] addr;
      logic [31:0] data;
      bit          ray_end;
      bit          last;
   } beat_t;

   beat_t       exp_q [$];
   logic [31:0] beat_log [$];
   logic [31:0] ray_log [$];
   bit          m_run;
   bit          m_done;
   int          m_acc;
   logic [31:0] m_base;
   logic [31:0] m_nan;
   bit          accepted;
   int          done_pulses;
   bit          ready_rand;
   int          n_assert;
   int          n_fail;

   ray_sample_collector #(
      .DATA_W          (32),
      .OUT_DIM         (OD),
      .SAMPLE_CNT      (SC),
      .SAMPLES_PER_RAY (SPR),
      .FIFO_DEPTH      (FD),
      .ADDR_W          (32)
   ) dut (
      .clk        (clk),
      .rst_n      (rst_n),
      .start      (start),
      .base_addr  (base_addr),
      .busy       (busy),
      .done       (done),
      .in_data    (in_data),
      .in_valid   (in_valid),
      .in_ready   (in_ready),
      .wr_addr    (wr_addr),
      .wr_data    (wr_data),
      .wr_valid   (wr_valid),
      .wr_ready   (wr_ready),
      .wr_ray_end (wr_ray_end)
`ifdef RAY_COLLECT_NAN_CNT_EN
      ,
      .nan_cnt    (nan_cnt)
`endif
   );

   // Free-running clock, 10 time units per cycle.
   initial clk = 1'b0;
   always #5 clk = ~clk;

   function automatic bit isNan(input logic [31:0] w);
      return (w[30:23] == 8'hFF) && (w[22:0] != 23'd0);
   endfunction

   task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_assert++;
      assert (obs === exp) else begin
         n_fail++;
         $error("[TB] FAIL %s: observed 0x%08h, expected 0x%08h", tag, obs, exp);
      end
   endtask

   task automatic applyStimulus(input logic [31:0] w0, input logic [31:0] w1,
                                input logic [31:0] w2, input logic [31:0] w3, input bit valid);
      in_data[0] = w0;
      in_data[1] = w1;
      in_data[2] = w2;
      in_data[3] = w3;
      in_valid   = valid;
   endtask

   // Expected beats of one accepted sample: consecutive words, byte addresses.
   task automatic modelAccept();
      for (int i = 0; i < OD; i++) begin
         beat_t b;
         b.addr    = m_base + 32'((m_acc * OD + i) * 4);
         b.data    = in_data[i];
         b.ray_end = (i == OD - 1) && ((m_acc % SPR) == SPR - 1);
         b.last    = (i == OD - 1) && (m_acc == SC - 1);
         exp_q.push_back(b);
      end
      m_acc++;
   endtask

   task automatic modelReset();
      exp_q.delete();
      m_run  = 0;
      m_done = 0;
      m_acc  = 0;
      m_base = '0;
      m_nan  = '0;
   endtask

   // Called at a falling edge with inputs already driven: compare outputs,
   // then advance the model across the coming rising edge.
   task automatic tick();
      bit    exp_ready;
      bit    new_done;
      int    occ;
      beat_t b;
      #1;
      occ       = (exp_q.size() + OD - 1) / OD;
      exp_ready = m_run && (occ < FD) && (m_acc < SC);
      checkOutput("busy", busy, m_run);
      checkOutput("done", done, m_done);
      checkOutput("in_ready", in_ready, exp_ready);
      checkOutput("wr_valid", wr_valid, m_run && exp_q.size() != 0);
      if (m_run && exp_q.size() != 0) begin
         checkOutput("wr_addr", wr_addr, exp_q[0].addr);
         checkOutput("wr_data", wr_data, exp_q[0].data);
         checkOutput("wr_ray_end", wr_ray_end, exp_q[0].ray_end);
      end else begin
         checkOutput("wr_data_idle", wr_data, 32'd0);
         checkOutput("wr_ray_end_idle", wr_ray_end, 32'd0);
      end
`ifdef RAY_COLLECT_NAN_CNT_EN
      checkOutput("nan_cnt", nan_cnt, m_nan);
`endif
      if (done === 1'b1) done_pulses++;
      if (wr_valid && wr_ready) beat_log.push_back(wr_addr);
      if (wr_valid && wr_ready && wr_ray_end) ray_log.push_back(wr_addr);

      accepted = 0;
      new_done = 0;
      if (!m_run && !m_done) begin
         if (start) begin
            m_run  = 1;
            m_base = base_addr;
            m_acc  = 0;
            m_nan  = '0;
            exp_q.delete();
         end
      end else if (m_run) begin
         if (wr_ready && exp_q.size() != 0) begin
            b = exp_q.pop_front();
            if (isNan(b.data) && m_nan != 32'hFFFF_FFFF) m_nan = m_nan + 32'd1;
            if (b.last) begin
               m_run    = 0;
               new_done = 1;
            end
         end
         if (in_valid && exp_ready) begin
            modelAccept();
            accepted = 1;
         end
      end
      m_done = new_done;
      @(negedge clk);
   endtask

   task automatic step();
      if (ready_rand) wr_ready = ($urandom_range(0, 3) != 0);
      tick();
   endtask

   task automatic startJob(input logic [31:0] b);
      beat_log.delete();
      ray_log.delete();
      done_pulses = 0;
      base_addr   = b;
      start       = 1'b1;
      tick();
      start       = 1'b0;
   endtask

   // Offer one sample until the collector takes it, within a cycle budget.
   task automatic sendSample(input logic [31:0] w0, input logic [31:0] w1,
                             input logic [31:0] w2, input logic [31:0] w3);
      int n;
      applyStimulus(w0, w1, w2, w3, 1'b1);
      n = 0;
      do begin
         step();
         n++;
      end while (!accepted && n < 100);
      checkOutput("accept_timeout", 32'(accepted), 32'd1);
      in_valid = 1'b0;
   endtask

   task automatic sendRandom(input int count, input bit gaps);
      for (int k = 0; k < count; k++) begin
         if (gaps && $urandom_range(0, 2) == 0) begin
            applyStimulus($urandom, $urandom, $urandom, $urandom, 1'b0);
            step();
         end
         sendSample($urandom, $urandom, $urandom, $urandom);
      end
   endtask

   task automatic drainJob();
      int n;
      n = 0;
      while (done_pulses == 0 && n < 400) begin
         step();
         n++;
      end
      step();
      step();
      checkOutput("done_pulses", 32'(done_pulses), 32'd1);
   endtask

   initial begin
      n_assert    = 0;
      n_fail      = 0;
      done_pulses = 0;
      ready_rand  = 0;
      rst_n       = 1'b0;
      start       = 1'b0;
      base_addr   = '0;
      wr_ready    = 1'b0;
      applyStimulus('0, '0, '0, '0, 1'b0);
      modelReset();

      $display("[TB] reset state");
      #3;
      checkOutput("rst_busy", busy, 32'd0);
      checkOutput("rst_in_ready", in_ready, 32'd0);
      checkOutput("rst_wr_valid", wr_valid, 32'd0);
      checkOutput("rst_wr_addr", wr_addr, 32'd0);
      @(negedge clk);
      rst_n = 1'b1;
      tick();
      tick();

      $display("[TB] basic sample and ray markers");
      wr_ready = 1'b1;
      startJob(32'h0000_1000);
      sendSample(32'd1, 32'd2, 32'd3, 32'd4);
      start     = 1'b1;
      base_addr = 32'hDEAD_0000;
      tick();
      start     = 1'b0;
      sendRandom(SC - 1, 1'b0);
      drainJob();
      checkOutput("basic_beat0", beat_log[0], 32'h0000_1000);
      checkOutput("basic_beat3", beat_log[3], 32'h0000_100C);
      checkOutput("ray_end_count", 32'(ray_log.size()), 32'd2);
      checkOutput("ray_end_0", ray_log[0], 32'h0000_103C);
      checkOutput("ray_end_1", ray_log[1], 32'h0000_107C);

      $display("[TB] backpressure and full FIFO");
      wr_ready = 1'b0;
      startJob(32'h0000_4000);
      sendRandom(FD, 1'b0);
      applyStimulus(32'hA5A5_0001, 32'hA5A5_0002, 32'hA5A5_0003, 32'hA5A5_0004, 1'b1);
      repeat (3) tick();
      checkOutput("bp_full_in_ready", in_ready, 32'd0);
      wr_ready = 1'b1;
      sendSample(32'hA5A5_0001, 32'hA5A5_0002, 32'hA5A5_0003, 32'hA5A5_0004);
      ready_rand = 1;
      sendRandom(SC - FD - 1, 1'b1);
      drainJob();
      checkOutput("bp_beat_total", 32'(beat_log.size()), 32'(SC * OD));

      $display("[TB] address wrap");
      startJob(32'hFFFF_FFF8);
      sendRandom(SC, 1'b1);
      drainJob();
      checkOutput("wrap_beat1", beat_log[1], 32'hFFFF_FFFC);
      checkOutput("wrap_beat2", beat_log[2], 32'h0000_0000);

      $display("[TB] reset mid-job");
      ready_rand = 0;
      wr_ready   = 1'b0;
      startJob(32'h0000_3000);
      sendRandom(3, 1'b0);
      tick();
      #2;
      rst_n    = 1'b0;
      start    = 1'b0;
      in_valid = 1'b0;
      #1;
      checkOutput("mid_rst_busy", busy, 32'd0);
      checkOutput("mid_rst_done", done, 32'd0);
      checkOutput("mid_rst_in_ready", in_ready, 32'd0);
      checkOutput("mid_rst_wr_valid", wr_valid, 32'd0);
      checkOutput("mid_rst_wr_data", wr_data, 32'd0);
      checkOutput("mid_rst_wr_addr", wr_addr, 32'd0);
      checkOutput("mid_rst_ray_end", wr_ray_end, 32'd0);
      modelReset();
      @(negedge clk);
      rst_n = 1'b1;
      tick();
      ready_rand = 1;
      startJob(32'h0000_2000);
      sendRandom(SC, 1'b1);
      drainJob();
      checkOutput("post_rst_beat0", beat_log[0], 32'h0000_2000);

`ifdef RAY_COLLECT_NAN_CNT_EN
      $display("[TB] NaN counter");
      ready_rand = 0;
      wr_ready   = 1'b1;
      startJob(32'h0000_0000);
      sendSample(32'h7FC0_0000, 32'h7F80_0000, 32'hFFFF_FFFF, 32'h3F80_0000);
      repeat (5) tick();
      checkOutput("nan_cnt_sample", nan_cnt, 32'd2);
      sendRandom(SC - 1, 1'b0);
      drainJob();
`endif

      $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
      $finish;
   end

endmodule
